// File: rtl/jtsdram_pkg.sv
// rtl/jtsdram_pkg.sv - shared sizes and FSM encodings for the SDRAM test arbiter
// Encodings are fixed widths so they can be probed directly on a logic analyser.
package jtsdram_pkg;

  localparam int NBANK = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACK  = 2'd1,
    ARB_RDY  = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_RUN   = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/jtsdram_rr4.sv
// rtl/jtsdram_rr4.sv - combinational 4-way round-robin picker
// Searches last+1, last+2, ... (mod 4); the nearest requester after last wins.
module jtsdram_rr4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt,
  output logic       any
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt = last;
    any = |req;
    idx = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) gnt = idx;
    end
  end

endmodule

// File: rtl/jtsdram_arb.sv
// rtl/jtsdram_arb.sv - SDRAM read-port arbiter and test-pass sequencer for four bank checkers
// One read outstanding, round-robin grants; start/done/bad aggregation with a stall watchdog.
module jtsdram_arb
  import jtsdram_pkg::*;
#(
  parameter int TOUTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                loop,
  output logic [NBANK-1:0]    bank_start,
  input  logic [NBANK-1:0]    bank_rd,
  input  logic [NBANK*AW-1:0] bank_addr,
  input  logic [NBANK-1:0]    bank_done,
  input  logic [NBANK-1:0]    bank_bad,
  output logic [NBANK-1:0]    bank_ack,
  output logic [NBANK-1:0]    bank_rdy,
  output logic [DW-1:0]       bank_dout,
  output logic                sdram_rd,
  output logic [1:0]          sdram_ba,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [DW-1:0]       sdram_dout,
  output logic                busy,
  output logic [NBANK-1:0]    bad,
  output logic                timeout,
  output logic [15:0]         passes
);

  arb_state_t       arb_q;
  seq_state_t       seq_q;
  logic [1:0]       gnt_q;
  logic [1:0]       last_q;
  logic             rd_q;
  logic [1:0]       ba_q;
  logic [AW-1:0]    addr_q;
  logic [NBANK-1:0] start_q;
  logic [NBANK-1:0] bad_q;
  logic             tout_q;
  logic [15:0]      passes_q;
  logic [TOUTW-1:0] wd_q;

  logic [1:0]       pick_gnt;
  logic             pick_any;
  logic [AW-1:0]    addr_d;
  logic [15:0]      passes_d;
  logic             wd_fire;

  jtsdram_rr4 u_rr4 (
    .req  (bank_rd),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign addr_d   = bank_addr[pick_gnt*AW +: AW];
  assign passes_d = (&passes_q) ? passes_q : passes_q + 16'd1;
  // A rdy in the same cycle as the all-ones count still counts as progress.
  assign wd_fire  = (seq_q == SEQ_RUN) && !sdram_rdy && (&wd_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      arb_q  <= ARB_IDLE;
      gnt_q  <= 2'd0;
      last_q <= 2'd3;
      rd_q   <= 1'b0;
      ba_q   <= 2'd0;
      addr_q <= '0;
    end else if (wd_fire) begin
      arb_q <= ARB_IDLE;
      rd_q  <= 1'b0;
    end else begin
      case (arb_q)
        ARB_IDLE: begin
          if (pick_any) begin
            gnt_q  <= pick_gnt;
            ba_q   <= pick_gnt;
            addr_q <= addr_d;
            rd_q   <= 1'b1;
            arb_q  <= ARB_ACK;
          end
        end
        ARB_ACK: begin
          if (sdram_ack) begin
            rd_q  <= 1'b0;
            arb_q <= ARB_RDY;
          end
        end
        ARB_RDY: begin
          if (sdram_rdy) begin
            last_q <= gnt_q;
            arb_q  <= ARB_IDLE;
          end
        end
        default: arb_q <= ARB_IDLE;
      endcase
    end
  end

  // Handshakes are only meaningful for the current grant, so route them there.
  always_comb begin
    bank_ack        = '0;
    bank_rdy        = '0;
    bank_ack[gnt_q] = sdram_ack & (arb_q == ARB_ACK);
    bank_rdy[gnt_q] = sdram_rdy & (arb_q == ARB_RDY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_q    <= SEQ_IDLE;
      start_q  <= '0;
      bad_q    <= '0;
      tout_q   <= 1'b0;
      passes_q <= 16'd0;
      wd_q     <= '0;
    end else begin
      start_q <= '0;
      case (seq_q)
        SEQ_IDLE: begin
          if (start) begin
            bad_q    <= '0;
            tout_q   <= 1'b0;
            passes_q <= 16'd0;
            start_q  <= '1;
            seq_q    <= SEQ_START;
          end
        end
        SEQ_START: seq_q <= SEQ_WAIT;
        SEQ_WAIT: begin
          wd_q  <= '0;
          seq_q <= SEQ_RUN;
        end
        SEQ_RUN: begin
          bad_q <= bad_q | bank_bad;
          if (sdram_rdy) wd_q <= '0;
          else           wd_q <= wd_q + 1'b1;
          if (wd_fire) begin
            tout_q <= 1'b1;
            seq_q  <= SEQ_IDLE;
          end else if ((&bank_done) && (arb_q == ARB_IDLE)) begin
            seq_q <= SEQ_DONE;
          end
        end
        SEQ_DONE: begin
          passes_q <= passes_d;
          if (loop) begin
            start_q <= '1;
            seq_q   <= SEQ_START;
          end else begin
            seq_q <= SEQ_IDLE;
          end
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign bank_start = start_q;
  assign bank_dout  = sdram_dout;
  assign sdram_rd   = rd_q;
  assign sdram_ba   = ba_q;
  assign sdram_addr = addr_q;
  assign busy       = (seq_q != SEQ_IDLE);
  assign bad        = bad_q;
  assign timeout    = tout_q;
  assign passes     = passes_q;

endmodule

// File: tb/tb_jtsdram_arb.sv
// tb/tb_jtsdram_arb.sv - randomized bench for jtsdram_arb against a behavioural reference
// Controller and checker models drive the DUT; a pass-level reference predicts every output.
module tb_jtsdram_arb;

  localparam int TW    = 4;
  localparam int WDMAX = (1 << TW) - 1;
  localparam int NREAD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, loop;
  logic [3:0]  bank_start, bank_rd, bank_done, bank_bad, bank_ack, bank_rdy, bad;
  logic [87:0] bank_addr;
  logic [31:0] bank_dout, sdram_dout;
  logic        sdram_rd, sdram_ack, sdram_rdy, busy, timeout;
  logic [1:0]  sdram_ba;
  logic [21:0] sdram_addr;
  logic [15:0] passes;

  jtsdram_arb #(.TOUTW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop),
    .bank_start(bank_start), .bank_rd(bank_rd), .bank_addr(bank_addr),
    .bank_done(bank_done), .bank_bad(bank_bad), .bank_ack(bank_ack),
    .bank_rdy(bank_rdy), .bank_dout(bank_dout), .sdram_rd(sdram_rd),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout), .busy(busy), .bad(bad),
    .timeout(timeout), .passes(passes)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: at most one outstanding read, plus the pass phase.
  bit          m_has, m_acked, m_rd, m_tout;
  int          m_g, m_last, m_ph, m_quiet, m_passes;
  logic [1:0]  m_ba;
  logic [21:0] m_addr;
  logic [3:0]  m_bad;

  // Controller and checker models.
  bit          c_acked, no_rdy, stray_rdy, rand_lat, auto_chk;
  int          c_cnt, ack_lat, rdy_lat, corrupt;
  logic [1:0]  c_ba;
  logic [21:0] c_addr;
  int          k_left [4];
  logic [21:0] k_addr [4];
  logic [3:0]  k_rd, k_done, k_bad;

  int          cyc = 0, start_pulses = 0, last_start_cyc = 0;
  bit          prev_rd = 0, got_ack = 0;
  logic [3:0]  ack_seen;
  logic [1:0]  grants[$];

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++)
      if (req[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  function automatic logic [31:0] mem_data(input logic [1:0] b, input logic [21:0] a);
    return {b, a, 8'h5A};
  endfunction

  task automatic model_reset();
    m_has = 0; m_acked = 0; m_rd = 0; m_tout = 0; m_g = 0; m_last = 3;
    m_ph = 0; m_quiet = 0; m_passes = 0; m_ba = 0; m_addr = 0; m_bad = 0;
  endtask

  task automatic model_step();
    bit arb_free, abort;
    int g;
    if (!rst) begin
      model_reset();
    end else begin
      arb_free = !m_has;
      abort = (m_ph == 3) && !sdram_rdy && (m_quiet == WDMAX);
      if (abort) begin
        m_has = 0; m_rd = 0;
      end else if (!m_has) begin
        g = rr_pick(bank_rd, m_last);
        if (g >= 0) begin
          m_has = 1; m_acked = 0; m_g = g; m_rd = 1;
          m_ba = 2'(g); m_addr = bank_addr[g*22 +: 22];
        end
      end else if (!m_acked) begin
        if (sdram_ack) begin m_acked = 1; m_rd = 0; end
      end else if (sdram_rdy) begin
        m_last = m_g; m_has = 0;
      end
      case (m_ph)
        0: if (start) begin m_bad = 0; m_tout = 0; m_passes = 0; m_ph = 1; end
        1: m_ph = 2;
        2: begin m_ph = 3; m_quiet = 0; end
        3: begin
          m_bad |= bank_bad;
          if (abort) begin m_tout = 1; m_ph = 0; end
          else if ((&bank_done) && arb_free) m_ph = 4;
          m_quiet = (sdram_rdy || abort) ? 0 : m_quiet + 1;
        end
        4: begin
          if (m_passes < 16'hFFFF) m_passes++;
          m_ph = loop ? 1 : 0;
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic ctl_reset();
    c_acked = 0; c_cnt = 0; stray_rdy = 0; sdram_ack = 0; sdram_rdy = 0;
  endtask

  task automatic models_drive();
    sdram_ack = 0;
    sdram_rdy = stray_rdy;
    if (c_acked) begin
      if (!no_rdy && c_cnt >= rdy_lat) begin
        sdram_rdy  = 1;
        sdram_dout = mem_data(c_ba, c_addr) ^ ((corrupt == int'(c_ba)) ? 32'h1 : 32'h0);
        c_acked = 0; c_cnt = 0;
        if (rand_lat) rdy_lat = $urandom_range(0, 2);
      end else c_cnt++;
    end else if (sdram_rd) begin
      if (c_cnt >= ack_lat) begin
        sdram_ack = 1; c_acked = 1; c_cnt = 0; c_ba = sdram_ba; c_addr = sdram_addr;
        if (rand_lat) ack_lat = $urandom_range(0, 2);
      end else c_cnt++;
    end
    if (auto_chk) begin
      for (int b = 0; b < 4; b++) begin
        if (bank_start[b]) begin
          k_left[b] = NREAD; k_done[b] = 0; k_bad[b] = 0; k_rd[b] = 1;
          k_addr[b] = 22'($urandom);
        end
        bank_addr[b*22 +: 22] = k_addr[b];
      end
      bank_rd = k_rd; bank_done = k_done; bank_bad = k_bad;
    end
  endtask

  task automatic cycle();
    logic [3:0] ea, er;
    #1;
    ea = (m_has && !m_acked && sdram_ack) ? 4'(1 << m_g) : 4'b0;
    er = (m_has && m_acked && sdram_rdy) ? 4'(1 << m_g) : 4'b0;
    check("bank_ack", bank_ack, ea);
    check("bank_rdy", bank_rdy, er);
    check("bank_dout", bank_dout, sdram_dout);
    if (sdram_ack) begin got_ack = 1; ack_seen = bank_ack; end
    if (auto_chk) begin
      for (int b = 0; b < 4; b++) begin
        if (bank_ack[b]) k_rd[b] = 0;
        if (bank_rdy[b]) begin
          if (bank_dout != mem_data(2'(b), k_addr[b])) k_bad[b] = 1;
          k_left[b]--;
          if (k_left[b] == 0) k_done[b] = 1;
          else begin k_rd[b] = 1; k_addr[b] = 22'($urandom); end
        end
      end
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("sdram_rd", sdram_rd, m_rd);
    check("sdram_ba", sdram_ba, m_ba);
    check("sdram_addr", sdram_addr, m_addr);
    check("bank_start", bank_start, (m_ph == 1) ? 4'hF : 4'h0);
    check("busy", busy, m_ph != 0);
    check("bad", bad, m_bad);
    check("timeout", timeout, m_tout);
    check("passes", passes, 16'(m_passes));
    if (bank_start == 4'hF) begin start_pulses++; last_start_cyc = cyc; end
    if (sdram_rd && !prev_rd) grants.push_back(sdram_ba);
    prev_rd = sdram_rd;
    models_drive();
  endtask

  task automatic do_reset();
    auto_chk = 0; bank_rd = 0; bank_done = 0; bank_bad = 0; start = 0; loop = 0;
    k_rd = 0; k_done = 0; k_bad = 0;
    ctl_reset();
    rst = 0;
    cycle();
    rst = 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin cycle(); n++; end
    check(tag, busy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && m_has; i++) cycle();
    check("drain", sdram_rd, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int prev_p;
    rst = 0; start = 0; loop = 0; bank_rd = 0; bank_addr = '0; bank_done = 0;
    bank_bad = 0; sdram_dout = 0; no_rdy = 0; rand_lat = 0; auto_chk = 0;
    corrupt = -1; ack_lat = 2; rdy_lat = 2; ack_seen = 0;
    k_rd = 0; k_done = 0; k_bad = 0;
    for (int b = 0; b < 4; b++) begin k_left[b] = 0; k_addr[b] = 0; end
    ctl_reset();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_sdram_rd", sdram_rd, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_passes", passes, 16'd0);
    check("rst_bank_start", bank_start, 4'h0);
    rst = 1;

    // All four banks requesting continuously: strict rotation 0,1,2,3,0.
    do_reset();
    ack_lat = 2; rdy_lat = 2;
    bank_addr = {$urandom, $urandom, $urandom};
    bank_rd = 4'hF;
    grants.delete();
    for (int i = 0; i < 80 && grants.size() < 5; i++) cycle();
    check("t1_ngrants", grants.size(), 5);
    for (int i = 0; i < grants.size() && i < 5; i++) check("t1_order", grants[i], i % 4);
    bank_rd = 0;
    drain();

    // Single requester, bank 2.
    bank_addr = '0;
    bank_addr[2*22 +: 22] = 22'h155AA;
    bank_rd = 4'b0100;
    cycle();
    check("t2_rd", sdram_rd, 1'b1);
    check("t2_addr", sdram_addr, 22'h155AA);
    check("t2_ba", sdram_ba, 2'd2);
    bank_rd = 0;
    got_ack = 0;
    for (int i = 0; i < 10 && !got_ack; i++) cycle();
    check("t2_ack", ack_seen, 4'b0100);
    drain();

    // One full pass with clean data.
    rand_lat = 1; auto_chk = 1; corrupt = -1; no_rdy = 0; loop = 0;
    start_pulses = 0;
    start = 1; cycle(); start = 0;
    wait_idle("t3_idle", 2000);
    check("t3_pulses", start_pulses, 1);
    check("t3_passes", passes, 16'd1);
    check("t3_bad", bad, 4'b0000);

    // Bank 1 sees corrupted data over looping passes.
    corrupt = 1; loop = 1;
    start = 1; cycle(); start = 0;
    prev_p = 0;
    for (int i = 0; i < 3000 && passes < 16'd4; i++) begin
      cycle();
      if (int'(passes) != prev_p) begin
        check("t4_bad_pass", bad, 4'b0010);
        prev_p = int'(passes);
      end
    end
    check("t4_reach", passes, 16'd4);
    loop = 0;
    wait_idle("t4_idle", 2000);
    check("t4_passes", passes, 16'd5);
    check("t4_bad", bad, 4'b0010);
    check("t4_timeout", timeout, 1'b0);

    // Controller never answers with rdy.
    corrupt = -1; no_rdy = 1;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 200 && !timeout; i++) cycle();
    check("t5_timeout", timeout, 1'b1);
    check("t5_latency", cyc - last_start_cyc, 18);
    check("t5_rd", sdram_rd, 1'b0);
    check("t5_busy", busy, 1'b0);

    // Reset while waiting for rdy, then a stray rdy.
    do_reset();
    no_rdy = 1; rand_lat = 0; ack_lat = 0;
    bank_rd = 4'b0001;
    cycle();
    bank_rd = 0;
    got_ack = 0;
    for (int i = 0; i < 10 && !got_ack; i++) cycle();
    check("t6_ack", got_ack, 1'b1);
    rst = 0; ctl_reset();
    cycle();
    rst = 1;
    stray_rdy = 1; sdram_rdy = 1;
    #1;
    check("t6_stray_rdy", bank_rdy, 4'b0000);
    cycle();
    stray_rdy = 0; sdram_rdy = 0;
    check("t6_rd", sdram_rd, 1'b0);
    check("t6_ba", sdram_ba, 2'd0);
    check("t6_addr", sdram_addr, 22'd0);
    check("t6_timeout", timeout, 1'b0);
    check("t6_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
